// File: rtl/fp_sub_pkg.sv
// Shared types and constants for the multi-cycle single-precision subtractor.
package fp_sub_pkg;
  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int MEXT_W = 25;
  localparam int MAX_SH = 25;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'd254;
  localparam logic [EXP_W-1:0] EXP_INF = 8'hFF;
  localparam logic [31:0] POS_ZERO = 32'h0000_0000;
  localparam logic [31:0] POS_INF  = 32'h7F80_0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_ADD,
    S_NORM,
    S_DONE
  } state_t;
endpackage

// File: rtl/fp_operand_unpack.sv
// Splits an IEEE-754 single into sign, exponent, extended mantissa and zero flag.
module fp_operand_unpack
  import fp_sub_pkg::*;
(
  input  logic [31:0]       op,
  output logic              sign,
  output logic [EXP_W-1:0]  exp,
  output logic [MEXT_W-1:0] mant,
  output logic              zero
);
  // Denormals are flushed: exponent 0 is treated as an exact zero.
  assign sign = op[31];
  assign exp  = op[30:23];
  assign zero = (op[30:23] == '0);
  assign mant = zero ? '0 : {2'b01, op[FRAC_W-1:0]};
endmodule

// File: rtl/fp_subtractor_multi_cycle.sv
// Multi-cycle a - b: aligns one bit per cycle, adds magnitudes, normalizes one bit per cycle.
module fp_subtractor_multi_cycle
  import fp_sub_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] res
);
  state_t              state;
  logic                sa, sb, sign, shift_a;
  logic [MEXT_W-1:0]   ma, mb, m;
  logic [EXP_W-1:0]    ex;
  logic [4:0]          cnt;

  logic                a_sign, b_sign, a_zero, b_zero;
  logic [EXP_W-1:0]    a_exp, b_exp;
  logic [MEXT_W-1:0]   a_mant, b_mant;

  logic [EXP_W-1:0]    cap_ex;
  logic [4:0]          cap_cnt;
  logic                cap_shift_a;
  logic [MEXT_W-1:0]   mag_sum, mag_diff;

  fp_operand_unpack u_unpack_a (.op(a), .sign(a_sign), .exp(a_exp), .mant(a_mant), .zero(a_zero));
  fp_operand_unpack u_unpack_b (.op(b), .sign(b_sign), .exp(b_exp), .mant(b_mant), .zero(b_zero));

  function automatic logic [4:0] sat_shift(input logic [EXP_W-1:0] d);
    return (d > EXP_W'(MAX_SH)) ? 5'(MAX_SH) : d[4:0];
  endfunction

  // A zero operand needs no alignment; the result takes the other exponent.
  always_comb begin
    cap_ex      = a_exp;
    cap_cnt     = '0;
    cap_shift_a = 1'b0;
    if (a_zero || b_zero) begin
      cap_ex      = a_zero ? b_exp : a_exp;
      cap_shift_a = a_zero;
    end else if (a_exp >= b_exp) begin
      cap_cnt = sat_shift(a_exp - b_exp);
    end else begin
      cap_ex      = b_exp;
      cap_shift_a = 1'b1;
      cap_cnt     = sat_shift(b_exp - a_exp);
    end
  end

  // Both mantissas are below 2^24, so the sum fits in the extended width.
  assign mag_sum  = ma + mb;
  assign mag_diff = (ma >= mb) ? (ma - mb) : (mb - ma);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      res       <= POS_ZERO;
      sa        <= 1'b0;
      sb        <= 1'b0;
      sign      <= 1'b0;
      shift_a   <= 1'b0;
      ma        <= '0;
      mb        <= '0;
      m         <= '0;
      ex        <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            sa       <= a_sign;
            sb       <= ~b_sign;
            ma       <= a_mant;
            mb       <= b_mant;
            ex       <= cap_ex;
            cnt      <= cap_cnt;
            shift_a  <= cap_shift_a;
            in_ready <= 1'b0;
            state    <= S_ALIGN;
          end
        end
        S_ALIGN: begin
          if (cnt == '0) begin
            state <= S_ADD;
          end else begin
            if (shift_a) ma <= ma >> 1;
            else         mb <= mb >> 1;
            cnt <= cnt - 5'd1;
          end
        end
        S_ADD: begin
          if (sa == sb) begin
            m    <= mag_sum;
            sign <= sa;
          end else begin
            m    <= mag_diff;
            sign <= (ma == mb) ? 1'b0 : ((ma > mb) ? sa : sb);
          end
          state <= S_NORM;
        end
        S_NORM: begin
          // Exact cancellation and underflow both produce +0.
          if (m == '0) begin
            sign  <= 1'b0;
            ex    <= '0;
            state <= S_DONE;
          end else if (m[MEXT_W-1]) begin
            if (ex == EXP_MAX) begin
              ex <= EXP_INF;
              m  <= '0;
            end else begin
              ex <= ex + 8'd1;
              m  <= m >> 1;
            end
            state <= S_DONE;
          end else if (m[FRAC_W]) begin
            state <= S_DONE;
          end else if (ex == 8'd1) begin
            sign  <= 1'b0;
            ex    <= '0;
            m     <= '0;
            state <= S_DONE;
          end else begin
            m  <= m << 1;
            ex <= ex - 8'd1;
          end
        end
        S_DONE: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            res       <= {sign, ex, m[FRAC_W-1:0]};
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          state    <= S_IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fp_subtractor_multi_cycle.sv
// Randomized and directed bench for fp_subtractor_multi_cycle against a numeric model.
module tb_fp_subtractor_multi_cycle;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] res;

  fp_subtractor_multi_cycle dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .res(res)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] r;
    int          lat;
    int          acc;
  } exp_t;

  exp_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  bit          hold = 1'b0;
  bit          prev_valid = 1'b0;
  logic [31:0] held_res = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Numeric reference: align, signed integer sum, then normalize the magnitude.
  function automatic void model(input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] r, output int lat);
    int     ex_a, ex_b, e, cnt, k;
    longint ma, mb, s, mag;
    bit     neg, fin;
    ex_a = int'(x[30:23]);
    ex_b = int'(y[30:23]);
    ma = (ex_a == 0) ? 0 : (longint'(x[22:0]) + (longint'(1) << 23));
    mb = (ex_b == 0) ? 0 : (longint'(y[22:0]) + (longint'(1) << 23));
    cnt = 0;
    if (ex_a == 0) e = ex_b;
    else if (ex_b == 0) e = ex_a;
    else if (ex_a >= ex_b) begin
      e = ex_a; cnt = (ex_a - ex_b > 25) ? 25 : ex_a - ex_b; mb = mb >> cnt;
    end else begin
      e = ex_b; cnt = (ex_b - ex_a > 25) ? 25 : ex_b - ex_a; ma = ma >> cnt;
    end
    s   = (x[31] ? -ma : ma) - (y[31] ? -mb : mb);
    neg = (s < 0);
    mag = neg ? -s : s;
    k = 0;
    r = 32'h0;
    fin = (mag == 0);
    while (!fin) begin
      if (mag >= (longint'(1) << 24)) begin
        mag = mag >> 1;
        r = (e == 254) ? {neg, 8'hFF, 23'h0} : {neg, 8'(e + 1), mag[22:0]};
        fin = 1'b1;
      end else if (mag >= (longint'(1) << 23)) begin
        r = {neg, 8'(e), mag[22:0]};
        fin = 1'b1;
      end else if (e == 1) begin
        r = 32'h0;
        fin = 1'b1;
      end else begin
        mag = mag << 1; e--; k++;
      end
    end
    lat = cnt + k + 4;
  endfunction

  // One clock: check outputs at the falling edge, drive after the rising edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (rst_n) begin
      if (out_valid) begin
        chk("in_ready_while_valid", {31'b0, in_ready}, 32'd0);
        if (!prev_valid) begin
          chk("result_expected", {31'b0, exp_q.size() != 0}, 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q[0];
            chk("res", res, e.r);
            chk("latency", 32'(cyc - e.acc), 32'(e.lat));
          end
          held_res = res;
        end else begin
          chk("res_stable", res, held_res);
        end
        if (out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
      end
      prev_valid = out_valid;
    end
    @(posedge clk);
    #1;
    out_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
  endtask

  task automatic start_op(input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    int   g;
    a = x; b = y; in_valid = 1'b1;
    g = 0;
    while (!in_ready && g < 200) begin tick(); g++; end
    chk("in_ready_wait", {31'b0, in_ready}, 32'd1);
    model(x, y, e.r, e.lat);
    e.acc = cyc + 1;
    exp_q.push_back(e);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 200) begin tick(); g++; end
    chk("completion", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_op(input logic [31:0] x, input logic [31:0] y);
    start_op(x, y);
    wait_done();
  endtask

  localparam int ND = 9;
  logic [31:0] d_a   [ND] = '{32'h40400000, 32'h3F800000, 32'h3FC00000, 32'h3F800000, 32'h00000000,
                              32'h7F000000, 32'h00C00000, 32'h4F000000, 32'h3F800001};
  logic [31:0] d_b   [ND] = '{32'h3F800000, 32'h3F800000, 32'hBFC00000, 32'h3FC00000, 32'h40000000,
                              32'hFF000000, 32'h00800000, 32'h3F800000, 32'h3F800000};
  logic [31:0] d_res [ND] = '{32'h40000000, 32'h00000000, 32'h40400000, 32'hBF000000, 32'hC0000000,
                              32'h7F800000, 32'h00000000, 32'h4F000000, 32'h34000000};
  int          d_lat [ND] = '{5, 4, 4, 5, 4, 4, 4, 29, 27};

  function automatic logic [7:0] rand_exp(input logic [7:0] ref_e);
    int m, e;
    m = $urandom_range(0, 9);
    if (m == 0) return 8'd0;
    if (m < 6) begin
      e = int'(ref_e) + $urandom_range(0, 6) - 3;
      if (e < 1) e = 1;
      if (e > 254) e = 254;
      return 8'(e);
    end
    return 8'($urandom_range(1, 254));
  endfunction

  initial begin
    logic [31:0] r, x, y;
    int          l;
    logic [7:0]  ex;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", {31'b0, in_ready}, 32'd1);
    chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset_res", res, 32'h0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < ND; i++) begin
      model(d_a[i], d_b[i], r, l);
      chk("model_res", r, d_res[i]);
      chk("model_lat", 32'(l), 32'(d_lat[i]));
      do_op(d_a[i], d_b[i]);
    end

    // Backpressure: result held, no second accept while waiting.
    hold = 1'b1;
    out_ready = 1'b0;
    start_op(32'h40400000, 32'h3F800000);
    for (int g = 0; g < 100 && !out_valid; g++) tick();
    chk("bp_valid", {31'b0, out_valid}, 32'd1);
    a = 32'h3F800000; b = 32'h40000000; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
      chk("bp_res_hold", res, 32'h40000000);
    end
    in_valid = 1'b0;
    hold = 1'b0;
    wait_done();
    repeat (3) tick();
    chk("bp_no_extra", {31'b0, out_valid}, 32'd0);

    // Reset while aligning.
    start_op(32'h41000000, 32'h3F800000);
    tick();
    chk("pre_reset_busy", {31'b0, in_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", {31'b0, out_valid}, 32'd0);
    chk("abort_in_ready", {31'b0, in_ready}, 32'd1);
    chk("abort_res", res, 32'h0);
    exp_q.delete();
    prev_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    do_op(32'h41000000, 32'h3F800000);

    for (int n = 0; n < 300; n++) begin
      ex = 8'($urandom_range(1, 254));
      x = {1'($urandom_range(0, 1)), rand_exp(ex), 23'($urandom)};
      y = {1'($urandom_range(0, 1)), rand_exp(x[30:23]), 23'($urandom)};
      if ($urandom_range(0, 4) == 0) y[22:0] = x[22:0];
      do_op(x, y);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
